// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider.
//   DIV_WIDTH   default operand/result width (also the iteration count)
//   DIV_CNT_W   iteration-counter width for the default width
//   div_state_e FSM state encoding
package div_pkg;

   localparam int unsigned DIV_WIDTH = 16;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   p_i       partial remainder (always < divisor, so its top bit is implicit 0)
//   q_i       dividend/quotient shift register
//   d_i       divisor magnitude
//   p_next_c  partial remainder after this iteration
//   q_next_c  shift register after this iteration (new quotient bit in LSB)
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] p_next_c,
   output logic [WIDTH-1:0] q_next_c
);

   logic [WIDTH:0] p_sh_c;
   logic [WIDTH:0] t_c;

   // Shift in the next dividend bit, trial-subtract, restore on borrow.
   always_comb begin
      p_sh_c   = {p_i, q_i[WIDTH-1]};
      t_c      = p_sh_c - {1'b0, d_i};
      p_next_c = p_sh_c[WIDTH-1:0];
      q_next_c = {q_i[WIDTH-2:0], 1'b0};
      if (!t_c[WIDTH]) begin
         p_next_c = t_c[WIDTH-1:0];
         q_next_c = {q_i[WIDTH-2:0], 1'b1};
      end
   end

endmodule : div_step

// File: rtl/div_unit.sv
// div_unit: iterative 16-bit restoring divider (one quotient bit per cycle).
//   clk, rst_n   clock, asynchronous active-low reset
//   start        launch request, accepted only in IDLE
//   dividend     numerator, sampled on the accepting edge
//   divisor      denominator, sampled on the accepting edge
//   is_signed    two's-complement mode (only with DIV_SIGNED_EN defined)
//   busy         division in progress
//   done         one-cycle result-valid pulse
//   quotient     result quotient, held until the next done
//   remainder    result remainder, held until the next done
//   div_by_zero  divisor was zero, held with the results
//   overflow     signed -2^(W-1) / -1, held with the results
// Build option: DIV_SIGNED_EN enables signed division; otherwise all
// division is unsigned, is_signed is ignored and overflow is always 0.
module div_unit
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             dbz_pend_q, dbz_pend_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] step_p_c, step_q_c;
   logic [WIDTH-1:0] dd_mag_c, dv_mag_c;
   logic [WIDTH-1:0] quo_res_c, rem_res_c;
   logic             ovf_c;

`ifdef DIV_SIGNED_EN
   logic             ovf_pend_q, ovf_pend_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dd_neg_c, dv_neg_c;

   // Operand magnitudes at start; result signs reapplied on the output load.
   always_comb begin
      dd_neg_c  = is_signed & dividend[WIDTH-1];
      dv_neg_c  = is_signed & divisor[WIDTH-1];
      dd_mag_c  = dd_neg_c ? (~dividend + WIDTH'(1)) : dividend;
      dv_mag_c  = dv_neg_c ? (~divisor + WIDTH'(1)) : divisor;
      ovf_c     = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
      quo_res_c = neg_quo_q ? (~q_q + WIDTH'(1)) : q_q;
      rem_res_c = neg_rem_q ? (~p_q + WIDTH'(1)) : p_q;
   end
`else
   logic unused_is_signed;
   assign unused_is_signed = is_signed;

   always_comb begin
      dd_mag_c  = dividend;
      dv_mag_c  = divisor;
      ovf_c     = 1'b0;
      quo_res_c = q_q;
      rem_res_c = p_q;
   end
`endif

   div_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .p_i      (p_q),
      .q_i      (q_q),
      .d_i      (d_q),
      .p_next_c (step_p_c),
      .q_next_c (step_q_c)
   );

   // Next-state, datapath and output-register logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      p_d        = p_q;
      q_d        = q_q;
      d_d        = d_q;
      dbz_pend_d = dbz_pend_q;
      done_d     = 1'b0;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dbz_d      = dbz_q;
      ovf_d      = ovf_q;
`ifdef DIV_SIGNED_EN
      ovf_pend_d = ovf_pend_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d = '0;
               p_d   = '0;
               if (divisor == '0) begin
                  // Raw dividend is kept for the divide-by-zero remainder.
                  state_d    = ST_DONE;
                  q_d        = dividend;
                  d_d        = '0;
                  dbz_pend_d = 1'b1;
`ifdef DIV_SIGNED_EN
                  ovf_pend_d = 1'b0;
                  neg_quo_d  = 1'b0;
                  neg_rem_d  = 1'b0;
`endif
               end else begin
                  state_d    = ST_RUN;
                  q_d        = dd_mag_c;
                  d_d        = dv_mag_c;
                  dbz_pend_d = 1'b0;
`ifdef DIV_SIGNED_EN
                  ovf_pend_d = ovf_c;
                  neg_quo_d  = dd_neg_c ^ dv_neg_c;
                  neg_rem_d  = dd_neg_c;
`endif
               end
            end
         end
         ST_RUN: begin
            p_d   = step_p_c;
            q_d   = step_q_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Final cycle: every result output is rewritten with the pulse.
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (dbz_pend_q) begin
               quo_d = '1;
               rem_d = q_q;
               dbz_d = 1'b1;
               ovf_d = 1'b0;
            end else begin
               quo_d = quo_res_c;
               rem_d = rem_res_c;
               dbz_d = 1'b0;
`ifdef DIV_SIGNED_EN
               ovf_d = ovf_pend_q;
`else
               ovf_d = ovf_c;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Busy covers the iterations and the finishing cycle of a real division.
      busy_d = (state_d == ST_RUN) || ((state_q == ST_RUN) && (state_d == ST_DONE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         p_q        <= '0;
         q_q        <= '0;
         d_q        <= '0;
         dbz_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
         ovf_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
         ovf_pend_q <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         p_q        <= p_d;
         q_q        <= q_d;
         d_q        <= d_d;
         dbz_pend_q <= dbz_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dbz_q      <= dbz_d;
         ovf_q      <= ovf_d;
`ifdef DIV_SIGNED_EN
         ovf_pend_q <= ovf_pend_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule : div_unit
